uart_char_rx: RTL and testbench
===============================

# uart_char_rx

Serial character receiver feeding the text overlay path of the VGA controller. It deserialises 8N1 asynchronous frames arriving on the single-bit `data` line and buffers the received bytes in a small show-ahead FIFO. The glyph/letter renderer pops character codes from that FIFO at its own pace. It runs on `master_clk` (50 MHz), upstream of the clock divider and pixel pipeline.

## Interface

**Parameters**
- `CLKS_PER_BIT`, 434: `master_clk` cycles per serial bit (50 MHz / 115200). Legal values are 4 to 65535.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two, 2 to 64.

**Ports**
- `master_clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data`  in  1  asynchronous serial line; idles high.
- `rd_en`  in  1  pop request from the renderer.
- `char_out`  out  8  FIFO head byte; valid while `char_valid`=1.
- `char_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples 0.
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation

**Input synchroniser**
- Two-flop synchroniser on `data` produces `rx_s`; both flops reset to 1.
- All FSM decisions use `rx_s` only.

**Receive FSM** (states IDLE, START, DATA, STOP; bit-timer `tmr`; bit index `idx` 0..7; shift register `sh`)
- IDLE: when `rx_s`=0, go to START with `tmr`=0.
- START: when `tmr` = CLKS_PER_BIT/2−1 (integer division), sample `rx_s`.
  - If 1: glitch; return to IDLE, nothing pushed, no error.
  - If 0: go to DATA with `tmr`=0 and `idx`=0.
- DATA: when `tmr` = CLKS_PER_BIT−1, sample `rx_s` into `sh[idx]` (LSB first), then `tmr`=0 and `idx`++.
  - After `idx`=7 is sampled, go to STOP.
- STOP: when `tmr` = CLKS_PER_BIT−1, sample `rx_s`.
  - If 1: push `sh` into the FIFO.
  - If 0: pulse `frame_err`, discard the byte.
  - Either way, go directly to IDLE. The FSM does not wait for the stop-bit end, so the next start edge can be caught half a bit early.
- Line held low in IDLE (a break) is treated as a frame that fails its stop bit. The FSM stays in IDLE until `rx_s`=1 is seen again. It only re-arms on a fresh high→low transition.

**FIFO**
- Show-ahead: `char_out` = entry at the read pointer.
- `rd_en` while empty is ignored.
- Push while full and no pop in the same cycle: the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop in the same cycle:
  - Full FIFO: both happen, count unchanged, no overflow.
  - Empty FIFO: only the push happens; the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` ranges 0..FIFO_DEPTH.

**Reset**
- Reset values: FSM in IDLE; `tmr`, `idx`, `sh` = 0; pointers and count = 0.
- Output reset values: `char_out`=0x00, `char_valid`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0.
- Reset asserted mid-frame aborts the frame. After release, the receiver waits for IDLE plus a new falling edge, so the remainder of an interrupted frame is never decoded as a start bit unless it produces a genuine high→low edge.

## Timing

- Let E be the first cycle with `rx_s`=0 in IDLE.
- Start sample: cycle E+1+CLKS_PER_BIT/2−1.
- Data bit k sample: start sample + (k+1)·CLKS_PER_BIT.
- Stop sample: start sample + 9·CLKS_PER_BIT.
- Push registers on the edge after the stop sample. `char_valid` and `fifo_count` update that same cycle.
- `frame_err` is high for exactly one cycle: the cycle after the stop sample.
- Pop: `rd_en` high at cycle t ⇒ `char_out` shows the next entry and `fifo_count` is decremented at t+1.
- Back-to-back frames at exactly CLKS_PER_BIT per bit, and with ±2% baud mismatch, must be received without loss.

## Test plan

Benches use CLKS_PER_BIT=8 and FIFO_DEPTH=4.

- **Single frame:** send byte 0x4D (8N1) with `rd_en`=0 → `char_valid`=1, `char_out`=0x4D, `fifo_count`=1, `frame_err` never high.
- **Back-to-back frames:** send 0x41, 0x42, 0x43 with no idle gap, then pulse `rd_en` three times → reads 0x41, 0x42, 0x43 in order, then `char_valid`=0.
- **Start glitch and bad stop bit:**
  - 3-cycle low pulse on idle `data` → no push, no `frame_err`, FSM back in IDLE.
  - Frame 0x55 with stop bit driven 0 → one-cycle `frame_err`, `fifo_count` stays 0.
- **Overflow:**
  - Send 5 bytes 0x10..0x14 with no reads → `fifo_count`=4, `overflow`=1, reads return 0x10..0x13.
  - Full FIFO with `rd_en` in the push cycle → count stays 4, `overflow` unchanged.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 of 0xA5, release, then send 0x33 → every output holds its reset value during reset, afterwards only 0x33 is received.

Source files
------------

// File: rtl/uart_char_rx.sv
// uart_char_rx
// Serial character receiver for the VGA text overlay. Deserialises 8N1 frames
// from the asynchronous `data` line and queues received bytes in a show-ahead
// FIFO that the glyph renderer drains at its own pace.
//
// Ports:
//   master_clk  in   system clock, all logic on rising edge
//   reset_n     in   asynchronous active-low reset
//   data        in   asynchronous serial line, idles high
//   rd_en       in   pop request from the renderer
//   char_out    out  FIFO head byte (0x00 while empty)
//   char_valid  out  FIFO not empty
//   fifo_count  out  current FIFO occupancy, 0..FIFO_DEPTH
//   frame_err   out  one-cycle pulse when a stop bit samples low
//   overflow    out  sticky, set when a byte is dropped on a full FIFO
module uart_char_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         master_clk,
    input  logic                         reset_n,
    input  logic                         data,
    input  logic                         rd_en,
    output logic [7:0]                   char_out,
    output logic                         char_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_err,
    output logic                         overflow
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   tmr;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          rx_meta, rx_s;
    logic [1:0]    sync_vld;
    logic          armed;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          push, pop, wr;

    // Two-flop synchroniser. sync_vld marks when rx_s carries the real line
    // level rather than the reset preset of the flops.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= data;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // armed: a genuine high level has been seen since the last frame ended,
    // so the next low is a real falling edge. Keeps a held-low break or the
    // tail of a frame cut by reset from being decoded as a start bit.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tmr       <= '0;
            idx       <= '0;
            sh        <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tmr <= '0;
                    if (rx_s && sync_vld[1]) begin
                        armed <= 1'b1;
                    end else if (!rx_s && armed) begin
                        armed <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (tmr == HALF_M1) begin
                        tmr <= '0;
                        if (rx_s) begin
                            // Glitch: line already back high at mid start bit.
                            armed <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= '0;
                            state <= DATA;
                        end
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                DATA: begin
                    if (tmr == BIT_M1) begin
                        tmr     <= '0;
                        sh[idx] <= rx_s;
                        idx     <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                STOP: begin
                    // Return at mid stop bit so the next start edge is not missed.
                    if (tmr == BIT_M1) begin
                        tmr       <= '0;
                        frame_err <= !rx_s;
                        armed     <= rx_s;
                        state     <= IDLE;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push is taken straight from the stop-sample cycle; sh is complete then.
    assign push = (state == STOP) && (tmr == BIT_M1) && rx_s;
    assign pop  = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr   = push && ((count != FULL) || pop);

    always_ff @(posedge master_clk) begin
        if (wr) mem[wp] <= sh;
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && (count == FULL) && !pop) overflow <= 1'b1;
        end
    end

    assign char_valid = (count != '0);
    assign fifo_count = count;
    assign char_out   = char_valid ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx
// Directed plus randomized bench for uart_char_rx (CLKS_PER_BIT=8,
// FIFO_DEPTH=4). Frames are bit-banged on `data`; a queue-based model of the
// byte stream, sticky overflow and frame-error count supplies expected values.
module tb_uart_char_rx;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       master_clk = 1'b0;
    logic       reset_n    = 1'b0;
    logic       data       = 1'b1;
    logic       rd_en      = 1'b0;
    logic [7:0] char_out;
    logic       char_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    uart_char_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .data       (data),
        .rd_en      (rd_en),
        .char_out   (char_out),
        .char_valid (char_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 master_clk = ~master_clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         exp_fe  = 0;

    // frame_err observation: count high cycles and rising edges separately so
    // a stretched pulse shows up as a difference.
    int   fe_cycles = 0;
    int   fe_pulses = 0;
    logic fe_prev   = 1'b0;
    always @(negedge master_clk) begin
        if (frame_err) fe_cycles <= fe_cycles + 1;
        if (frame_err && !fe_prev) fe_pulses <= fe_pulses + 1;
        fe_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (exp_q.size() != 0) head = exp_q[0];
        chk({tag, ".count"},    32'(fifo_count), 32'(exp_q.size()));
        chk({tag, ".valid"},    32'(char_valid), 32'(exp_q.size() != 0));
        chk({tag, ".char"},     32'(char_out),   32'(head));
        chk({tag, ".overflow"}, 32'(overflow),   32'(exp_ovf));
        chk({tag, ".fe_pulses"}, 32'(fe_pulses), 32'(exp_fe));
        chk({tag, ".fe_cycles"}, 32'(fe_cycles), 32'(exp_fe));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".char"},      32'(char_out),   32'h0);
        chk({tag, ".valid"},     32'(char_valid), 32'h0);
        chk({tag, ".count"},     32'(fifo_count), 32'h0);
        chk({tag, ".frame_err"}, 32'(frame_err),  32'h0);
        chk({tag, ".overflow"},  32'(overflow),   32'h0);
    endtask

    // Sends start + 8 data bits LSB first + stop bit, CPB cycles each.
    // pop_at_push raises rd_en exactly in the cycle the byte is pushed.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit pop_at_push);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            data = fr[i];
            if (i == 9 && pop_at_push) begin
                repeat (6) @(negedge master_clk);
                rd_en = 1'b1;
                @(negedge master_clk);
                rd_en = 1'b0;
                @(negedge master_clk);
            end else begin
                repeat (CPB) @(negedge master_clk);
            end
        end
        if (pop_at_push && exp_q.size() != 0) void'(exp_q.pop_front());
        if (stop_bit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic pop_chk(input string tag);
        rd_en = 1'b1;
        @(negedge master_clk);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(negedge master_clk);
        check_reset_outputs(tag);
        @(negedge master_clk);
        reset_n = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (4) @(negedge master_clk);
    endtask

    initial begin
        logic [7:0] b;
        bit         sb;

        // Reset state
        repeat (2) @(negedge master_clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("idle");

        // Single frame
        send_frame(8'h4D, 1'b1, 1'b0);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("single");
        pop_chk("single_pop");

        // Back-to-back frames, no idle gap
        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        send_frame(8'h43, 1'b1, 1'b0);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("b2b");
        pop_chk("b2b_pop0");
        pop_chk("b2b_pop1");
        pop_chk("b2b_pop2");
        pop_chk("pop_empty");

        // 3-cycle start glitch, then a clean frame proves the FSM re-armed
        data = 1'b0;
        repeat (3) @(negedge master_clk);
        data = 1'b1;
        repeat (30) @(negedge master_clk);
        check_state("glitch");
        send_frame(8'h5A, 1'b1, 1'b0);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("after_glitch");
        pop_chk("after_glitch_pop");

        // Bad stop bit
        send_frame(8'h55, 1'b0, 1'b0);
        data = 1'b1;
        repeat (6) @(negedge master_clk);
        check_state("bad_stop");

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("overflow");
        for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_pop%0d", i));

        // Full FIFO with a pop in the push cycle: no overflow, count stays 4
        do_reset("rst_a");
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
        send_frame(8'h24, 1'b1, 1'b1);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("full_pushpop");
        for (int i = 0; i < 4; i++) pop_chk($sformatf("fp_pop%0d", i));

        // Reset in data bit 3 of 0xA5; released while the line is still low
        send_frame(8'h77, 1'b1, 1'b0);
        b = 8'hA5;
        data = 1'b0;
        repeat (CPB) @(negedge master_clk);
        for (int i = 0; i < 3; i++) begin
            data = b[i];
            repeat (CPB) @(negedge master_clk);
        end
        data = b[3];
        repeat (4) @(negedge master_clk);
        reset_n = 1'b0;
        @(negedge master_clk);
        check_reset_outputs("midrst_a");
        @(negedge master_clk);
        check_reset_outputs("midrst_b");
        reset_n = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge master_clk);
        data = b[4];
        repeat (CPB) @(negedge master_clk);
        data = 1'b1;
        repeat (100) @(negedge master_clk);
        check_state("midrst_idle");
        send_frame(8'h33, 1'b1, 1'b0);
        data = 1'b1;
        repeat (4) @(negedge master_clk);
        check_state("midrst_33");
        pop_chk("midrst_pop");

        // Randomized frames, gaps, bad stops and pops
        for (int n = 0; n < 16; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(b, sb, 1'b0);
            data = 1'b1;
            if (sb) repeat ($urandom_range(0, 5)) @(negedge master_clk);
            else    repeat ($urandom_range(4, 10)) @(negedge master_clk);
            check_state($sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) != 0) pop_chk($sformatf("rnd_pop%0d", n));
        end
        repeat (4) @(negedge master_clk);
        while (exp_q.size() != 0) pop_chk("drain");
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
